// File: rtl/struct_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : struct_reader_pkg
// Description : Types and constants shared by the struct_t producer/consumer
//               path: the beat struct, default field offsets, checker states.
// Revision    : 1.0 - initial release
// ============================================================================
package struct_reader_pkg;

    // Field layout driven by the producer side
    typedef struct packed {
        int val100;
        int val200;
    } struct_t;

    // Default offsets the producer adds to value
    localparam int OFF_A_DEF = 100;
    localparam int OFF_B_DEF = 200;

    // Checker verdict state machine
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        FAIL = 2'd3
    } state_e;

endpackage : struct_reader_pkg
`default_nettype wire

// File: rtl/struct_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module      : struct_reader_fifo
// Description : DEPTH-entry 32-bit synchronous FIFO with registered head
//               outputs. A push that cannot be stored is reported on drop.
// Revision    : 1.0 - initial release
// ============================================================================
module struct_reader_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop_req,
    output logic        rd_valid,
    output logic [31:0] rd_value,
    output logic        full,
    output logic        drop
);

    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   C_FULL = (AW + 1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          rd_valid_q, rd_valid_d;
    logic [31:0]   rd_value_q, rd_value_d;
    logic          do_push, do_pop;
    logic [31:0]   head_d;

    // Pointer/occupancy update and next head selection; a push into the slot
    // that becomes the head must bypass the storage array.
    always_comb begin
        do_pop   = rd_valid_q && pop_req;
        full     = (count_q == C_FULL);
        do_push  = push && (!full || do_pop);
        drop     = push && full && !do_pop;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_data;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
        rd_valid_d = (count_d != '0);
        rd_value_d = rd_valid_d ? head_d : rd_value_q;
    end

    // Storage array; contents are don't-care while unoccupied
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Control and head registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_value_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_value_q <= rd_value_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_value = rd_value_q;

endmodule : struct_reader_fifo
`default_nettype wire

// File: rtl/struct_reader.sv
`default_nettype none
// ============================================================================
// Module      : struct_reader
// Description : Consumer-side self-checker for the struct_t path. Checks each
//               accepted beat against value+offset, counts mismatches, queues
//               values for a downstream reader and flags a verdict.
// Revision    : 1.0 - initial release
// ============================================================================
module struct_reader
    import struct_reader_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int OFF_A     = OFF_A_DEF,
    parameter int OFF_B     = OFF_B_DEF,
    parameter int ERR_W     = 8,
    parameter int RUN_BEATS = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_value,
    input  logic [31:0]      in_val100,
    input  logic [31:0]      in_val200,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [31:0]      rd_value,
    output logic [ERR_W-1:0] err_count,
    output logic             overflow,
    output logic             done,
    output logic             fail
);

    localparam int               BW        = $clog2(RUN_BEATS + 1);
    localparam logic [BW-1:0]    C_BEATS   = BW'(RUN_BEATS);
    localparam logic [ERR_W-1:0] C_ERR_MAX = {ERR_W{1'b1}};

    state_e           state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    struct_t          beat_s;
    logic [31:0]      exp_a, exp_b;
    logic             accept, mism;
    logic             fifo_full, fifo_drop;

    // Field check, saturating error count, beat counter and verdict
    always_comb begin
        beat_s.val100 = in_val100;
        beat_s.val200 = in_val200;
        exp_a  = in_value + 32'(OFF_A);
        exp_b  = in_value + 32'(OFF_B);
        accept = in_valid && ((state_q == IDLE) || (state_q == RUN));
        mism   = ($unsigned(beat_s.val100) != exp_a) ||
                 ($unsigned(beat_s.val200) != exp_b);
        err_d   = err_q;
        beat_d  = beat_q;
        state_d = state_q;
        if (accept) begin
            if (mism && (err_q != C_ERR_MAX)) begin
                err_d = err_q + ERR_W'(1);
            end
            beat_d  = beat_q + BW'(1);
            state_d = RUN;
            if (beat_d == C_BEATS) begin
                state_d = (err_d != '0) ? FAIL : DONE;
            end
        end
        overflow_d = overflow_q || fifo_drop;
        done_d     = (state_d == DONE);
        fail_d     = (state_d == FAIL);
    end

    // Checker state and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            err_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
        end
    end

    struct_reader_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (in_value),
        .pop_req   (rd_ready),
        .rd_valid  (rd_valid),
        .rd_value  (rd_value),
        .full      (fifo_full),
        .drop      (fifo_drop)
    );

    assign err_count = err_q;
    assign overflow  = overflow_q;
    assign done      = done_q;
    assign fail      = fail_q;

endmodule : struct_reader
`default_nettype wire
